// File: rtl/lcd_hd44780_ctrl_if.sv
// Host byte-write channel into the HD44780 controller.
interface lcd_hd44780_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;

    modport master (output req_valid, output req_rs, output req_data, input req_ready);
    modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780-class character-LCD controller: power-on init, host byte writes in
// 8- or 4-bit bus mode, cursor tracking with automatic row wrap.
module lcd_hd44780_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BUS_4BIT   = 0,
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int AUTO_WRAP  = 1,
    parameter int E_CYC      = 12,
    parameter int T_PWR_US   = 15000,
    parameter int T_INIT_US  = 4100,
    parameter int T_LONG_US  = 1530,
    parameter int T_SHORT_US = 39,
    parameter int T_DATA_US  = 43
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_hd44780_ctrl_if.slave  host,
    output logic               init_done,
    output logic               busy,
    output logic               RS,
    output logic               RW,
    output logic               E,
    output logic [7:0]         DATA
);
    // state    | meaning
    // PWR_WAIT | power-up delay after reset
    // SETUP    | RS/DATA driven, E low
    // E_HI     | E high
    // HOLD     | E low, RS/DATA held
    // WAIT     | LCD busy delay after a complete byte
    // WRAP     | load the row-change DDRAM address command
    // IDLE     | ready for a host byte
    typedef enum logic [2:0] {
        S_PWR_WAIT, S_SETUP, S_E_HI, S_HOLD, S_WAIT, S_WRAP, S_IDLE
    } state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CYC_US  = CLK_HZ / 1_000_000;
    localparam int D_PWR   = T_PWR_US * CYC_US;
    localparam int D_INIT  = T_INIT_US * CYC_US;
    localparam int D_LONG  = T_LONG_US * CYC_US;
    localparam int D_SHORT = T_SHORT_US * CYC_US;
    localparam int D_DATA  = T_DATA_US * CYC_US;
    localparam int D_MAX   = imax(imax(imax(D_PWR, D_INIT), imax(D_LONG, D_SHORT)), imax(D_DATA, E_CYC));
    localparam int CW      = $clog2(D_MAX + 1);
    localparam int N_INIT  = (BUS_4BIT != 0) ? 8 : 7;

    localparam logic [CW-1:0] PWR_LD  = CW'(D_PWR - 1);
    localparam logic [CW-1:0] INIT_LD = CW'(D_INIT - 1);
    localparam logic [CW-1:0] E_LD    = CW'(E_CYC - 1);
    localparam logic [7:0] FUNC_SET   = (BUS_4BIT != 0) ? ((ROWS > 1) ? 8'h28 : 8'h20)
                                                        : ((ROWS > 1) ? 8'h38 : 8'h30);

    // 8-bit mode skips the 4-bit-only 0x20 step, so its indices shift by one.
    function automatic logic [7:0] init_byte(input logic [3:0] s);
        logic [3:0] k;
        k = (BUS_4BIT != 0 || s < 4'd3) ? s : s + 4'd1;
        case (k)
            4'd0, 4'd1, 4'd2: init_byte = 8'h30;
            4'd3:             init_byte = 8'h20;
            4'd4:             init_byte = FUNC_SET;
            4'd5:             init_byte = 8'h0C;
            4'd6:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction

    function automatic logic [CW-1:0] byte_dly(input logic rs, input logic [7:0] b);
        if (rs)                        byte_dly = CW'(D_DATA - 1);
        else if (b inside {8'h01, 8'h02, 8'h03}) byte_dly = CW'(D_LONG - 1);
        else                           byte_dly = CW'(D_SHORT - 1);
    endfunction

    function automatic logic [6:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    row_base = 7'h00;
            2'd1:    row_base = 7'h40;
            2'd2:    row_base = 7'(COLS);
            default: row_base = 7'(64 + COLS);
        endcase
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    cur_byte, byte_nxt;
    logic          cur_rs, rs_nxt;
    logic          single, single_nxt;
    logic          nib, nib_nxt;
    logic [3:0]    step, step_nxt;
    logic          done_nxt, accept, wrap_clr, wrap_set, wrap_pend, strobe;
    logic [1:0]    row, row_nxt;
    logic [5:0]    col, col_nxt;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = (cnt == '0) ? '0 : cnt - CW'(1);
        byte_nxt   = cur_byte;
        rs_nxt     = cur_rs;
        single_nxt = single;
        nib_nxt    = nib;
        step_nxt   = step;
        done_nxt   = init_done;
        accept     = 1'b0;
        wrap_clr   = 1'b0;
        case (state)
            S_PWR_WAIT: if (cnt == '0) begin
                state_nxt  = S_SETUP;
                cnt_nxt    = E_LD;
                byte_nxt   = init_byte(4'd0);
                rs_nxt     = 1'b0;
                single_nxt = (BUS_4BIT != 0);
                nib_nxt    = 1'b0;
                step_nxt   = 4'd0;
            end
            S_SETUP: if (cnt == '0) begin
                state_nxt = S_E_HI;
                cnt_nxt   = E_LD;
            end
            S_E_HI: if (cnt == '0) begin
                state_nxt = S_HOLD;
                cnt_nxt   = E_LD;
            end
            S_HOLD: if (cnt == '0) begin
                if (BUS_4BIT != 0 && !single && !nib) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = E_LD;
                    nib_nxt   = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = (!init_done && step < 4'd3) ? INIT_LD : byte_dly(cur_rs, cur_byte);
                end
            end
            S_WAIT: if (cnt == '0) begin
                if (!init_done) begin
                    if (step == 4'(N_INIT - 1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt  = S_SETUP;
                        cnt_nxt    = E_LD;
                        step_nxt   = step + 4'd1;
                        byte_nxt   = init_byte(step + 4'd1);
                        rs_nxt     = 1'b0;
                        single_nxt = (BUS_4BIT != 0) && (step < 4'd3);
                        nib_nxt    = 1'b0;
                    end
                end else begin
                    state_nxt = wrap_pend ? S_WRAP : S_IDLE;
                end
            end
            S_WRAP: begin
                state_nxt  = S_SETUP;
                cnt_nxt    = E_LD;
                byte_nxt   = {1'b1, row_base(row)};
                rs_nxt     = 1'b0;
                single_nxt = 1'b0;
                nib_nxt    = 1'b0;
                wrap_clr   = 1'b1;
            end
            default: if (host.req_valid) begin
                accept     = 1'b1;
                state_nxt  = S_SETUP;
                cnt_nxt    = E_LD;
                byte_nxt   = host.req_data;
                rs_nxt     = host.req_rs;
                single_nxt = 1'b0;
                nib_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PWR_WAIT;
            cnt       <= PWR_LD;
            cur_byte  <= 8'h00;
            cur_rs    <= 1'b0;
            single    <= 1'b0;
            nib       <= 1'b0;
            step      <= 4'd0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_byte  <= byte_nxt;
            cur_rs    <= rs_nxt;
            single    <= single_nxt;
            nib       <= nib_nxt;
            step      <= step_nxt;
            init_done <= done_nxt;
        end
    end

    // Addresses outside every visible row leave the cursor where it was.
    always_comb begin
        int a;
        int b;
        row_nxt  = row;
        col_nxt  = col;
        wrap_set = 1'b0;
        a        = int'(host.req_data[6:0]);
        b        = 0;
        if (host.req_rs) begin
            if (col == 6'(COLS - 1)) begin
                col_nxt  = 6'd0;
                row_nxt  = (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;
                wrap_set = (AUTO_WRAP != 0);
            end else begin
                col_nxt = col + 6'd1;
            end
        end else if (host.req_data[7]) begin
            for (int r = 0; r < ROWS; r++) begin
                b = int'(row_base(2'(r)));
                if (a >= b && a < b + COLS) begin
                    row_nxt = 2'(r);
                    col_nxt = 6'(a - b);
                end
            end
        end else if (host.req_data inside {8'h01, 8'h02, 8'h03}) begin
            row_nxt = 2'd0;
            col_nxt = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= 2'd0;
            col       <= 6'd0;
            wrap_pend <= 1'b0;
        end else begin
            if (accept) begin
                row <= row_nxt;
                col <= col_nxt;
            end
            if (accept && wrap_set) wrap_pend <= 1'b1;
            else if (wrap_clr)      wrap_pend <= 1'b0;
        end
    end

    assign strobe         = (state == S_SETUP) || (state == S_E_HI) || (state == S_HOLD);
    assign host.req_ready = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign E              = (state == S_E_HI);
    assign RS             = strobe & cur_rs;
    assign RW             = 1'b0;

    always_comb begin
        DATA = 8'h00;
        if (strobe) begin
            if (BUS_4BIT != 0) DATA = {(nib ? cur_byte[3:0] : cur_byte[7:4]), 4'h0};
            else               DATA = cur_byte;
        end
    end
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: 8-bit and 4-bit instances, strobe scoreboard,
// table of host writes, wrap sequences and mid-transfer reset.
module tb_lcd_hd44780_ctrl;
    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         t;
    } strobe_t;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         busy;
        logic       wr;
        logic [7:0] wb;
    } vec_t;

    localparam logic [55:0] INIT8 = 56'h30_30_30_38_0C_01_06;
    localparam logic [95:0] INIT4 = 96'h30_30_30_20_20_80_00_C0_00_10_00_60;

    logic clk = 1'b0;
    logic rst_n;
    logic RS8, RW8, E8, done8, busy8;
    logic RS4, RW4, E4, done4, busy4;
    logic [7:0] DATA8, DATA4;
    int   total = 0;
    int   bad = 0;
    int   cyc;
    int   exp_done8, exp_done4;
    logic lownib_bad = 1'b0;
    logic e_prev [2];
    int   wid [2];
    logic [8:0] held [2];
    strobe_t q8 [$];
    strobe_t q4 [$];
    vec_t vt [14];

    lcd_hd44780_ctrl_if h8 ();
    lcd_hd44780_ctrl_if h4 ();

    lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .BUS_4BIT(0), .E_CYC(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .host(h8), .init_done(done8), .busy(busy8),
        .RS(RS8), .RW(RW8), .E(E8), .DATA(DATA8));

    lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .BUS_4BIT(1), .E_CYC(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .host(h4), .init_done(done4), .busy(busy4),
        .RS(RS4), .RW(RW4), .E(E4), .DATA(DATA4));

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) cyc=%0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic strobe_t mk(input logic rs, input logic [7:0] d, input int t);
        strobe_t s;
        s.rs = rs;
        s.d  = d;
        s.t  = t;
        return s;
    endfunction

    function automatic vec_t mkv(input logic rs, input logic [7:0] d, input int busy,
                                 input logic wr, input logic [7:0] wb);
        vec_t v;
        v.rs = rs; v.d = d; v.busy = busy; v.wr = wr; v.wb = wb;
        return v;
    endfunction

    function automatic int gap8(input int i);
        return (i < 3) ? 4100 : (i == 5) ? 1530 : 39;
    endfunction

    function automatic int gap4(input int i);
        if (i < 3)       return 4100;
        if (i == 3)      return 39;
        if (i % 2 == 0)  return 0;
        return (i == 9) ? 1530 : 39;
    endfunction

    // First E rise lands after the power wait plus one SETUP phase.
    task automatic push_init();
        int t;
        logic [55:0] i8;
        logic [95:0] i4;
        i8 = INIT8;
        i4 = INIT4;
        t = 15000 + 2;
        for (int i = 0; i < 7; i++) begin
            q8.push_back(mk(1'b0, i8[55-8*i -: 8], t));
            t = t + 6 + gap8(i);
        end
        exp_done8 = t - 2;
        t = 15000 + 2;
        for (int i = 0; i < 12; i++) begin
            q4.push_back(mk(1'b0, i4[95-8*i -: 8], t));
            t = t + 6 + gap4(i);
        end
        exp_done4 = t - 2;
    endtask

    task automatic mon(input int id, input logic e, input logic rs, input logic rw, input logic [7:0] d);
        strobe_t s;
        if (e && !e_prev[id]) begin
            if ((id == 0 && q8.size() == 0) || (id == 1 && q4.size() == 0)) begin
                chk($sformatf("sb_unexpected_dut%0d_data", id), int'(d), -1);
            end else begin
                if (id == 0) s = q8.pop_front();
                else         s = q4.pop_front();
                chk($sformatf("sb_rs_dut%0d", id), int'(rs), int'(s.rs));
                chk($sformatf("sb_data_dut%0d", id), int'(d), int'(s.d));
                chk($sformatf("sb_rw_dut%0d", id), int'(rw), 0);
                if (s.t >= 0) chk($sformatf("sb_time_dut%0d_%02h", id, s.d), cyc, s.t);
            end
            held[id] = {rs, d};
            wid[id]  = 1;
        end else if (e) begin
            chk($sformatf("e_hi_stable_dut%0d", id), int'({rs, d}), int'(held[id]));
            wid[id]++;
        end else if (e_prev[id]) begin
            chk($sformatf("e_width_dut%0d", id), wid[id], 2);
        end
        e_prev[id] = e;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev[0] = 1'b0;
            e_prev[1] = 1'b0;
        end else begin
            mon(0, E8, RS8, RW8, DATA8);
            mon(1, E4, RS4, RW4, DATA4);
            if (DATA4[3:0] != 4'h0) lownib_bad = 1'b1;
        end
    end

    task automatic wait_done(input int id, input int exp_t);
        int n = 0;
        while (n < 40000 && !((id == 0) ? done8 : done4)) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("init_done_time_dut%0d", id), cyc, exp_t);
    endtask

    task automatic busy_len(input string nm, input int exp);
        int n = 0;
        @(negedge clk);
        while (!h8.req_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, exp);
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        while (!h8.req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!h8.req_ready) begin
            chk("ready_timeout", int'(h8.req_ready), 1);
            return;
        end
        h8.req_valid = 1'b1;
        h8.req_rs    = v.rs;
        h8.req_data  = v.d;
        q8.push_back(mk(v.rs, v.d, -1));
        if (v.wr) q8.push_back(mk(1'b0, v.wb, -1));
        @(posedge clk);
        #1 h8.req_valid = 1'b0;
        busy_len($sformatf("busy_len_rs%0d_%02h", v.rs, v.d), v.busy);
        chk($sformatf("sb_drain_%02h", v.d), q8.size(), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        h8.req_valid = 1'b0; h8.req_rs = 1'b0; h8.req_data = 8'h00;
        h4.req_valid = 1'b0; h4.req_rs = 1'b0; h4.req_data = 8'h00;

        vt[0]  = mkv(1'b0, 8'h01, 1536, 1'b0, 8'h00);
        vt[1]  = mkv(1'b1, 8'h41,   49, 1'b0, 8'h00);
        vt[2]  = mkv(1'b0, 8'h0C,   45, 1'b0, 8'h00);
        vt[3]  = mkv(1'b0, 8'h02, 1536, 1'b0, 8'h00);
        vt[4]  = mkv(1'b1, 8'h42,   49, 1'b0, 8'h00);
        vt[5]  = mkv(1'b0, 8'h03, 1536, 1'b0, 8'h00);
        vt[6]  = mkv(1'b0, 8'h06,   45, 1'b0, 8'h00);
        vt[7]  = mkv(1'b0, 8'h8F,   45, 1'b0, 8'h00);
        vt[8]  = mkv(1'b1, 8'h5A,   95, 1'b1, 8'hC0);
        vt[9]  = mkv(1'b0, 8'hCE,   45, 1'b0, 8'h00);
        vt[10] = mkv(1'b1, 8'h43,   49, 1'b0, 8'h00);
        vt[11] = mkv(1'b0, 8'hFF,   45, 1'b0, 8'h00);
        vt[12] = mkv(1'b1, 8'h44,   95, 1'b1, 8'h80);
        vt[13] = mkv(1'b0, 8'hA0,   45, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        chk("rst_RS", int'(RS8), 0);
        chk("rst_RW", int'(RW8), 0);
        chk("rst_E", int'(E8), 0);
        chk("rst_DATA", int'(DATA8), 0);
        chk("rst_ready", int'(h8.req_ready), 0);
        chk("rst_init_done", int'(done8), 0);
        chk("rst_busy", int'(busy8), 1);
        chk("rst_busy4", int'(busy4), 1);

        // A byte offered during init must wait, then be taken once init is done.
        push_init();
        h8.req_valid = 1'b1; h8.req_rs = 1'b1; h8.req_data = 8'h99;
        q8.push_back(mk(1'b1, 8'h99, -1));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("ready_pre_init", int'(h8.req_ready), 0);
        wait_done(0, exp_done8);
        chk("ready_at_done", int'(h8.req_ready), 1);
        @(posedge clk);
        #1 h8.req_valid = 1'b0;
        busy_len("busy_len_pending_99", 49);
        wait_done(1, exp_done4);
        chk("q8_drain_init", q8.size(), 0);
        chk("q4_drain_init", q4.size(), 0);

        for (int i = 0; i < 14; i++) send(vt[i]);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++)
                send(mkv(1'b1, 8'(8'h61 + i), (i == 15) ? 95 : 49, i == 15, (k == 0) ? 8'hC0 : 8'h80));
        end
        send(mkv(1'b0, 8'hC5, 45, 1'b0, 8'h00));
        for (int i = 0; i < 11; i++)
            send(mkv(1'b1, 8'(8'h30 + i), (i == 10) ? 95 : 49, i == 10, 8'h80));

        h8.req_valid = 1'b1; h8.req_rs = 1'b1; h8.req_data = 8'h55;
        q8.push_back(mk(1'b1, 8'h55, -1));
        @(posedge clk);
        #1 h8.req_valid = 1'b0;
        n = 0;
        while (!E8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_e_seen", int'(E8), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_E", int'(E8), 0);
        chk("mid_rst_busy", int'(busy8), 1);
        chk("mid_rst_ready", int'(h8.req_ready), 0);
        chk("mid_rst_q8", q8.size(), 0);
        q8.delete();
        q4.delete();
        repeat (2) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_done(0, exp_done8);
        wait_done(1, exp_done4);
        chk("q8_drain_reinit", q8.size(), 0);
        chk("q4_drain_reinit", q4.size(), 0);
        chk("data4_low_nibble_zero", int'(lownib_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Parametrised HD44780-class character-LCD controller.
- Runs the power-on init sequence itself, then accepts command and data bytes from a host over a valid/ready handshake.
- Generates RS/RW/E/DATA with correct pulse timing and per-command busy delays, in 8-bit or 4-bit bus mode.
- Tracks the cursor and inserts DDRAM-address commands so text wraps line-by-line on ROWS x COLS panels.

Parameters:
- CLK_HZ, 50_000_000, clock frequency. CYC_US = CLK_HZ/1_000_000; must be an integer >= 1.
- BUS_4BIT, 0, 1 = 4-bit interface on DATA[7:4]; 0 = 8-bit.
- ROWS, 2, display rows (1, 2 or 4).
- COLS, 16, display columns (8..40).
- AUTO_WRAP, 1, 1 = insert a row-change command after the last column.
- E_CYC, 12, E high width in cycles (>= 230 ns); setup and hold phases are also E_CYC cycles each.
- T_PWR_US, 15000, wait after reset before the first init write.
- T_INIT_US, 4100, wait after each of the three init 0x30 writes.
- T_LONG_US, 1530, busy time for clear (0x01) and home (0x02/0x03).
- T_SHORT_US, 39, busy time for all other commands.
- T_DATA_US, 43, busy time for data (RS=1) writes.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, host has a byte.
- req_ready, out, 1, controller accepts the byte this cycle.
- req_rs, in, 1, 0 = command, 1 = character data.
- req_data, in, 8, byte to write.
- init_done, out, 1, init sequence complete; sticky until reset.
- busy, out, 1, high whenever not in IDLE.
- RS, out, 1, LCD register select.
- RW, out, 1, LCD read/write; tied 0 (write only).
- E, out, 1, LCD enable strobe.
- DATA, out, 8, LCD bus. In 4-bit mode DATA[3:0] = 0.

Behaviour:
- Reset (asynchronous assert, synchronous release) values:
  - RS=0, RW=0, E=0, DATA=0, req_ready=0, init_done=0, busy=1.
  - Cursor row=0, col=0. State=PWR_WAIT.
- All delay counters count in cycles: delay_us*CYC_US. A delay begins the cycle after HOLD ends.
- One bus write (a "strobe"):
  - SETUP: E=0, RS/DATA driven, E_CYC cycles.
  - E_HI: E=1, E_CYC cycles.
  - HOLD: E=0, RS/DATA held, E_CYC cycles.
  - In 4-bit mode a byte is two strobes: high nibble, then low nibble, back-to-back. A single delay follows the second strobe.
- State machine:
  - PWR_WAIT: wait T_PWR_US, then go to INIT.
  - INIT step 0..2: nibble/byte 0x30, each followed by T_INIT_US.
  - If BUS_4BIT, step 3 is a single strobe of 0x20, then T_SHORT_US.
  - Then full-byte function set: 0x38 (8-bit) or 0x28 (4-bit), with N=1 when ROWS>1, else 0x30/0x20.
  - Then 0x0C display on, 0x01 clear (T_LONG_US), 0x06 entry mode.
  - Then IDLE with init_done=1.
  - IDLE: req_ready=1 combinationally while in IDLE. Byte is accepted on the cycle req_valid & req_ready; the next cycle goes to SETUP with the byte latched. req_ready=0 from then until back in IDLE.
  - WAIT: delay is T_LONG_US if RS=0 and byte is 0x01..0x03, T_SHORT_US for other commands, T_DATA_US if RS=1.
  - After WAIT: go to WRAP if a wrap is pending, else IDLE.
  - WRAP: issue command 0x80|base(row), then go to IDLE.
- Row base addresses: 0x00, 0x40, COLS, 0x40+COLS for rows 0..3.
- Cursor tracking:
  - Data write: col+1. If col was COLS-1, col=0 and row=(row+1)%ROWS. When AUTO_WRAP=1, also set wrap pending.
  - Command 0x01 or 0x02/0x03: row=0, col=0.
  - Command with bit7=1: decode row/col from the address. An address outside the panel leaves the cursor unchanged.
  - Other commands: cursor unchanged.
- Requests arriving before init_done are not accepted (req_ready=0); they are not dropped by the host.
- Reset mid-transfer: E drops to 0 immediately and the init sequence restarts from PWR_WAIT.

Test Plan:
- CLK_HZ=1_000_000, E_CYC=2, BUS_4BIT=0, release reset:
  - No E for 15000 cycles; then strobes 0x30,0x30,0x30,0x38,0x0C,0x01,0x06 are observed.
  - The 0x01 is followed by 1530 idle cycles; init_done rises after the last 39-cycle wait.
- Same config, BUS_4BIT=1:
  - DATA[7:4] sequence 3,3,3,2, then pairs (2,8),(0,C),(0,1),(0,6). DATA[3:0]=0 throughout.
- After init, send req_rs=1, req_data=0x41:
  - One ready handshake; RS=1, DATA=0x41 stable across E high for 2 cycles.
  - req_ready returns after 43 delay cycles + 6 strobe cycles.
- Write 16 chars with ROWS=2, COLS=16:
  - After the 16th, a command 0xC0 is auto-issued before req_ready returns.
  - After 16 more, 0x80 is issued.
- Send 0x80|0x45 (row1 col5), then 11 chars: the wrap to 0x80 occurs after the 11th.
- Assert rst_n=0 during E_HI of a data write: E=0 and busy=1 in the same cycle; init restarts with a 15000-cycle wait.
